// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART clocking blocks.
//   UART_OVS          : oversample ticks per UART bit
//   SYSCLK_HZ         : nominal sysclk frequency the divisor constants assume
//   DIV_*             : integer + fractional divisors (sysclk cycles per os_tick)
//   baud_div_t        : divisor pair {div_int, div_frac}
//   MIN_DIV_INT       : smallest integer divisor the tick generator will accept
package uart_pkg;

  localparam int UART_OVS   = 16;
  localparam int SYSCLK_HZ  = 50_000_000;
  localparam int DIV_INT_W  = 16;
  localparam int DIV_FRAC_W = 4;
  localparam int MIN_DIV_INT = 2;

  typedef struct packed {
    logic [DIV_INT_W-1:0]  div_int;
    logic [DIV_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // 50 MHz / (rate * 16), fractional part in 1/16 cycle units
  localparam baud_div_t DIV_9600   = '{div_int: 16'd325, div_frac: 4'd8};
  localparam baud_div_t DIV_19200  = '{div_int: 16'd162, div_frac: 4'd12};
  localparam baud_div_t DIV_115200 = '{div_int: 16'd27,  div_frac: 4'd2};

endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: divisor configuration handshake.
//   cfg_valid    : producer offers a new divisor
//   cfg_ready    : generator can accept a new divisor
//   cfg_div_int  : requested integer divisor
//   cfg_div_frac : requested fractional divisor
//   cfg_err      : one-cycle pulse when an offered divisor is rejected
// master = configuration producer, slave = baud_tick_gen.
interface baud_tick_gen_if #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_div_int;
  logic [FRAC_W-1:0] cfg_div_frac;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_div_int, cfg_div_frac,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_div_int, cfg_div_frac,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/baud_tick_gen_period.sv
// frac_period_cnt: fractional-N period counter producing the oversample tick.
//   clk, reset      : clock, synchronous active-high reset
//   en, restart     : count enable, phase realign (clears cnt and frac_acc)
//   load/load_*     : latch a new divisor as pending (only while idle)
//   wrap            : combinational, high on the edge that raises os_tick
//   os_tick         : registered one-cycle oversample pulse
//   idle            : no divisor pending (drives cfg_ready)
//   div_int/frac    : active divisor
module frac_period_cnt
  import uart_pkg::*;
#(
  parameter int CNT_W        = DIV_INT_W,
  parameter int FRAC_W       = DIV_FRAC_W,
  parameter int DEF_DIV_INT  = 325,
  parameter int DEF_DIV_FRAC = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  input  logic              load,
  input  logic [CNT_W-1:0]  load_int,
  input  logic [FRAC_W-1:0] load_frac,
  output logic              wrap,
  output logic              os_tick,
  output logic              idle,
  output logic [CNT_W-1:0]  div_int,
  output logic [FRAC_W-1:0] div_frac
);

  logic [CNT_W-1:0]  cnt_r;
  logic [FRAC_W-1:0] acc_r;
  logic              os_tick_r;
  logic              idle_r;
  logic [CNT_W-1:0]  div_int_r, pend_int_r;
  logic [FRAC_W-1:0] div_frac_r, pend_frac_r;
  logic [FRAC_W:0]   sum_s;
  logic [CNT_W-1:0]  last_s;
  logic              at_end_s, wrap_s, apply_s;

  // Period end detection: the carry of frac_acc + div_frac stretches this period by one
  always_comb begin
    sum_s    = {1'b0, acc_r} + {1'b0, div_frac_r};
    last_s   = div_int_r - CNT_W'(1) + CNT_W'(sum_s[FRAC_W]);
    // >= keeps the counter bounded if a smaller divisor lands while cnt is held high
    at_end_s = en && (cnt_r >= last_s);
    wrap_s   = at_end_s && !restart;
    // pending divisor goes live on restart, at a wrap, or straight away while stalled
    apply_s  = !idle_r && (restart || !en || at_end_s);
  end

  // Period counter
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      cnt_r <= '0;
    end else if (at_end_s) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Fractional accumulator, cleared whenever the phase or the divisor changes
  always_ff @(posedge clk) begin
    if (reset || restart || apply_s) begin
      acc_r <= '0;
    end else if (at_end_s) begin
      acc_r <= sum_s[FRAC_W-1:0];
    end else begin
      acc_r <= acc_r;
    end
  end

  // Registered oversample pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      os_tick_r <= 1'b0;
    end else begin
      os_tick_r <= wrap_s;
    end
  end

  // Pending and active divisor registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_r      <= 1'b1;
      div_int_r   <= CNT_W'(DEF_DIV_INT);
      div_frac_r  <= FRAC_W'(DEF_DIV_FRAC);
      pend_int_r  <= '0;
      pend_frac_r <= '0;
    end else if (apply_s) begin
      idle_r     <= 1'b1;
      div_int_r  <= pend_int_r;
      div_frac_r <= pend_frac_r;
    end else if (load && idle_r) begin
      idle_r      <= 1'b0;
      pend_int_r  <= load_int;
      pend_frac_r <= load_frac;
    end else begin
      idle_r <= idle_r;
    end
  end

  assign wrap     = wrap_s;
  assign os_tick  = os_tick_r;
  assign idle     = idle_r;
  assign div_int  = div_int_r;
  assign div_frac = div_frac_r;

endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional baud generator for the UART RX/TX engines.
//   sysclk, reset : clock, synchronous active-high reset
//   en            : count enable (counters hold, ticks 0 when low)
//   restart       : realign to start of bit; next bit_tick lands mid-bit
//   cfg           : divisor configuration handshake (slave side)
//   os_tick       : one-cycle pulse at the oversample rate
//   bit_tick      : one-cycle pulse at the bit rate, coincident with os_tick
//   brclk         : legacy 50% square wave at the bit rate
//   cur_div_*     : active divisor
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CNT_W        = DIV_INT_W,
  parameter int FRAC_W       = DIV_FRAC_W,
  parameter int OVS          = UART_OVS,
  parameter int DEF_DIV_INT  = 325,
  parameter int DEF_DIV_FRAC = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              en,
  input  logic              restart,
  baud_tick_gen_if.slave    cfg,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              brclk,
  output logic [CNT_W-1:0]  cur_div_int,
  output logic [FRAC_W-1:0] cur_div_frac
);

  localparam int OS_W = $clog2(OVS);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVS - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVS / 2 - 1);
  localparam logic [OS_W-1:0] OS_HALF = OS_W'(OVS / 2);

  logic            accept_s, reject_s, load_s, wrap_s, idle_s;
  logic            err_r, bit_tick_r, brclk_r;
  logic [OS_W-1:0] os_cnt_r;

  // Classify an accepted offer as a legal divisor to hold, or one to reject
  always_comb begin
    accept_s = cfg.cfg_valid && idle_s;
    if (cfg.cfg_div_int < CNT_W'(MIN_DIV_INT)) begin
      reject_s = accept_s;
      load_s   = 1'b0;
    end else begin
      reject_s = 1'b0;
      load_s   = accept_s;
    end
  end

  // Rejection pulse
  always_ff @(posedge sysclk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= reject_s;
    end
  end

  // Oversample counter, bit tick and legacy square wave
  always_ff @(posedge sysclk) begin
    if (reset) begin
      os_cnt_r   <= '0;
      bit_tick_r <= 1'b0;
      brclk_r    <= 1'b1;
    end else if (restart) begin
      // half a bit of os_ticks remains, so the next bit_tick samples mid-bit
      os_cnt_r   <= OS_HALF;
      bit_tick_r <= 1'b0;
      brclk_r    <= 1'b1;
    end else if (wrap_s) begin
      os_cnt_r   <= (os_cnt_r == OS_LAST) ? '0 : os_cnt_r + OS_W'(1);
      bit_tick_r <= (os_cnt_r == OS_LAST);
      brclk_r    <= (os_cnt_r == OS_LAST || os_cnt_r == OS_MID) ? ~brclk_r : brclk_r;
    end else begin
      os_cnt_r   <= os_cnt_r;
      bit_tick_r <= 1'b0;
      brclk_r    <= brclk_r;
    end
  end

  frac_period_cnt #(
    .CNT_W        (CNT_W),
    .FRAC_W       (FRAC_W),
    .DEF_DIV_INT  (DEF_DIV_INT),
    .DEF_DIV_FRAC (DEF_DIV_FRAC)
  ) u_period (
    .clk       (sysclk),
    .reset     (reset),
    .en        (en),
    .restart   (restart),
    .load      (load_s),
    .load_int  (cfg.cfg_div_int),
    .load_frac (cfg.cfg_div_frac),
    .wrap      (wrap_s),
    .os_tick   (os_tick),
    .idle      (idle_s),
    .div_int   (cur_div_int),
    .div_frac  (cur_div_frac)
  );

  assign cfg.cfg_ready = idle_s;
  assign cfg.cfg_err   = err_r;
  assign bit_tick      = bit_tick_r;
  assign brclk         = brclk_r;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed bench for baud_tick_gen with hand-computed timing.
module tb_baud_tick_gen;

  logic        sysclk, reset, en, restart;
  logic        os_tick, bit_tick, brclk;
  logic [15:0] cur_div_int;
  logic [3:0]  cur_div_frac;
  int checks = 0;
  int errors = 0;
  int n, os_cnt, bit_cnt, lone_bit, bad;

  baud_tick_gen_if #(.CNT_W(16), .FRAC_W(4)) cfg_if ();

  baud_tick_gen #(
    .CNT_W(16), .FRAC_W(4), .OVS(16), .DEF_DIV_INT(325), .DEF_DIV_FRAC(8)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .en           (en),
    .restart      (restart),
    .cfg          (cfg_if),
    .os_tick      (os_tick),
    .bit_tick     (bit_tick),
    .brclk        (brclk),
    .cur_div_int  (cur_div_int),
    .cur_div_frac (cur_div_frac)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // which: 0 os_tick, 1 bit_tick, 2 brclk low, 3 brclk high; n = cycles waited, -1 on timeout
  task automatic wait_for(input int which, input int limit, output int cycles);
    logic hit;
    cycles = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      case (which)
        0:       hit = os_tick;
        1:       hit = bit_tick;
        2:       hit = ~brclk;
        default: hit = brclk;
      endcase
      if (hit === 1'b1) begin
        cycles = i;
        return;
      end
    end
  endtask

  task automatic offer(input logic [15:0] di, input logic [3:0] df);
    cfg_if.cfg_valid    = 1'b1;
    cfg_if.cfg_div_int  = di;
    cfg_if.cfg_div_frac = df;
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; restart = 1'b0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_div_int = 16'd0; cfg_if.cfg_div_frac = 4'd0;
    step(); step();

    // reset state
    check("rst_os_tick", os_tick, 1'b0);
    check("rst_bit_tick", bit_tick, 1'b0);
    check("rst_brclk", brclk, 1'b1);
    check("rst_cfg_ready", cfg_if.cfg_ready, 1'b1);
    check("rst_cfg_err", cfg_if.cfg_err, 1'b0);
    check("rst_div_int", cur_div_int, 16'd325);
    check("rst_div_frac", cur_div_frac, 4'd8);
    reset = 1'b0;

    // defaults: first counting cycle has cnt 0, so the tick lands 325 cycles on (its 326th cycle)
    wait_for(0, 400, n);  check("def_first_os", n, 325);
    wait_for(0, 400, n);  check("def_os_326", n, 326);
    wait_for(0, 400, n);  check("def_os_325", n, 325);
    // first bit_tick at 16 ticks = 5208 cycles; 976 already elapsed
    wait_for(1, 6000, n); check("def_first_bit", n, 4232);
    check("def_bit_has_os", os_tick, 1'b1);
    check("def_brclk_at_bit", brclk, 1'b1);
    wait_for(2, 3000, n); check("def_brclk_high", n, 2604);
    wait_for(3, 3000, n); check("def_brclk_low", n, 2604);
    check("def_bit_spacing", bit_tick, 1'b1);

    // 10 + 8/16 with restart: periods 10,11,..., first bit after 8 ticks = 84 cycles
    offer(16'd10, 4'd8);
    check("c10_ready_low", cfg_if.cfg_ready, 1'b0);
    check("c10_div_old", cur_div_int, 16'd325);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("c10_div_int", cur_div_int, 16'd10);
    check("c10_div_frac", cur_div_frac, 4'd8);
    check("c10_ready_back", cfg_if.cfg_ready, 1'b1);
    check("c10_brclk", brclk, 1'b1);
    check("c10_no_tick", os_tick, 1'b0);
    wait_for(0, 50, n);   check("c10_os_10", n, 10);
    wait_for(0, 50, n);   check("c10_os_11", n, 11);
    wait_for(1, 200, n);  check("c10_first_bit", n, 63);
    check("c10_brclk_falls", brclk, 1'b0);
    wait_for(1, 300, n);  check("c10_bit_spacing", n, 168);

    // illegal divisor
    offer(16'd1, 4'd3);
    check("bad_err_pulse", cfg_if.cfg_err, 1'b1);
    check("bad_ready", cfg_if.cfg_ready, 1'b1);
    check("bad_div_int", cur_div_int, 16'd10);
    step();
    check("bad_err_one_cycle", cfg_if.cfg_err, 1'b0);

    // 10/0 active, then 20/0 offered 3 cycles into a period
    offer(16'd10, 4'd0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("c10f0_frac", cur_div_frac, 4'd0);
    wait_for(0, 50, n);   check("c10f0_os", n, 10);
    step(); step(); step();
    offer(16'd20, 4'd0);
    check("c20_ready_low", cfg_if.cfg_ready, 1'b0);
    check("c20_div_still_10", cur_div_int, 16'd10);
    n = 0; bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      n++;
      if (os_tick === 1'b1) break;
      if (cfg_if.cfg_ready !== 1'b0) bad++;
    end
    check("c20_old_period_end", n, 6);
    check("c20_ready_held_low", bad, 0);
    check("c20_ready_on_apply", cfg_if.cfg_ready, 1'b1);
    check("c20_div_applied", cur_div_int, 16'd20);
    wait_for(0, 50, n);   check("c20_os_a", n, 20);
    wait_for(0, 50, n);   check("c20_os_b", n, 20);

    // en low for 37 cycles, 5 cycles into the first period after restart
    restart = 1'b1;
    step();
    restart = 1'b0;
    step(); step(); step(); step(); step();
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 37; i++) begin
      step();
      if (os_tick !== 1'b0 || bit_tick !== 1'b0) bad++;
    end
    en = 1'b1;
    check("stall_no_ticks", bad, 0);
    wait_for(0, 50, n);   check("stall_stretch", 5 + 37 + n, 57);
    os_cnt = 0; bit_cnt = 0; lone_bit = 0;
    for (int i = 0; i < 960; i++) begin
      step();
      if (os_tick === 1'b1) os_cnt++;
      if (bit_tick === 1'b1) bit_cnt++;
      if (bit_tick === 1'b1 && os_tick !== 1'b1) lone_bit++;
    end
    check("stall_os_count", os_cnt, 48);
    check("stall_bit_count", bit_cnt, 3);
    check("stall_bit_coincide", lone_bit, 0);
    check("stall_window_end_os", os_tick, 1'b1);
    wait_for(2, 300, n);  check("stall_brclk_fall", n, 140);

    // reset mid-bit with a divisor pending
    for (int i = 0; i < 100; i++) step();
    check("mid_brclk_low", brclk, 1'b0);
    offer(16'd40, 4'd5);
    check("mid_pending", cfg_if.cfg_ready, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    en = 1'b0;
    check("rst2_os_tick", os_tick, 1'b0);
    check("rst2_bit_tick", bit_tick, 1'b0);
    check("rst2_brclk", brclk, 1'b1);
    check("rst2_ready", cfg_if.cfg_ready, 1'b1);
    check("rst2_err", cfg_if.cfg_err, 1'b0);
    check("rst2_div_int", cur_div_int, 16'd325);
    check("rst2_div_frac", cur_div_frac, 4'd8);
    step();
    check("rst2_pend_dropped", cur_div_int, 16'd325);

    // with en low a pending divisor applies the cycle after acceptance
    offer(16'd12, 4'd0);
    check("en0_ready_low", cfg_if.cfg_ready, 1'b0);
    check("en0_div_old", cur_div_int, 16'd325);
    step();
    check("en0_ready_back", cfg_if.cfg_ready, 1'b1);
    check("en0_div_new", cur_div_int, 16'd12);
    check("en0_no_tick", os_tick, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/baud_tick_gen.md
Name: baud_tick_gen

Overview:
- Parametrised successor to the fixed 9600/153600 baud generator.
- Produces single-cycle oversample and bit-rate tick enables from sysclk. The free-running toggled clocks of the old block are replaced by enables; a legacy square-wave output is kept.
- Adds a runtime-programmable fractional divisor, a configuration handshake, and restart alignment for UART RX start-bit centring.
- Sits between sysclk and the UART RX/TX engines of the pipelined CPU.

Parameters:
- CNT_W, 16: width of the integer divisor and the period counter.
- FRAC_W, 4: width of the fractional divisor part.
- OVS, 16: oversample ticks per bit. Must be even and ≥4.
- DEF_DIV_INT, 325: reset integer divisor, in sysclk cycles per os_tick.
- DEF_DIV_FRAC, 8: reset fractional divisor, in 1/2^FRAC_W cycle units. 325.5 gives 9600×16 at 50 MHz.

Ports:
- sysclk, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- en, in, 1: count enable. When 0, all counters hold and ticks stay 0.
- restart, in, 1: realign phase to the start of a bit.
- cfg_valid, in, 1: new divisor offered.
- cfg_ready, out, 1: new divisor can be accepted.
- cfg_div_int, in, CNT_W: requested integer divisor.
- cfg_div_frac, in, FRAC_W: requested fractional divisor.
- cfg_err, out, 1: one-cycle pulse when a request is rejected.
- os_tick, out, 1: one-cycle pulse at the oversample rate.
- bit_tick, out, 1: one-cycle pulse at the bit rate. Always coincides with an os_tick.
- brclk, out, 1: legacy 50% square wave at the bit rate.
- cur_div_int, out, CNT_W: active integer divisor.
- cur_div_frac, out, FRAC_W: active fractional divisor.

Behaviour:
- Reset values:
  - div = DEF_DIV_INT/DEF_DIV_FRAC; cnt = 0; frac_acc = 0; os_cnt = 0; pending = 0.
  - os_tick = 0, bit_tick = 0, cfg_err = 0, brclk = 1, cfg_ready = 1.
  - A pending configuration is discarded. Reset mid-operation has the same effect in the next cycle.
- Period generation:
  - Each period P = div_int + c, where c is the carry of frac_acc + div_frac (mod 2^FRAC_W).
  - c is computed and frac_acc is updated at every period wrap.
  - cnt runs 0..P-1 while en = 1.
  - os_tick is a registered pulse asserted in the cycle after cnt == P-1.
  - Mean period = div_int + div_frac/2^FRAC_W.
  - The first os_tick appears P+1 cycles after the first en-high cycle following reset.
- Bit counting:
  - os_cnt counts 0..OVS-1 and increments on os_tick.
  - bit_tick is asserted with the os_tick on which os_cnt wraps from OVS-1.
  - brclk toggles on the os_ticks where os_cnt is at OVS/2-1 and at OVS-1.
- en = 0:
  - cnt, frac_acc, os_cnt and brclk hold; ticks are 0.
  - Counting resumes from the held state; no tick is lost or duplicated.
- restart = 1 (honoured regardless of en; highest priority after reset):
  - Sets cnt = 0, frac_acc = 0, os_cnt = OVS/2, brclk = 1. Ticks are 0 in that cycle.
  - The next bit_tick therefore arrives OVS/2 oversample periods later, at mid-bit, and brclk falls with it.
  - A pending configuration is applied in the same cycle.
- Configuration handshake:
  - Transfer occurs when cfg_valid and cfg_ready are both 1.
  - If cfg_div_int < 2: the request is rejected, cfg_err pulses high in the next cycle, cfg_ready stays 1, and the divisor is unchanged.
  - Otherwise: the request is latched as pending and cfg_ready = 0 from the next cycle.
- Applying a pending configuration:
  - Applied at the next period wrap, i.e. the cycle that raises os_tick. The current period completes with the old divisor.
  - If en = 0, it is applied in the cycle after acceptance.
  - On apply: frac_acc clears, cur_div_* update, and cfg_ready returns to 1 in the following cycle.
- Simultaneous events:
  - restart with a period wrap: restart wins and no tick is emitted.
  - cfg_valid while pending: not accepted (cfg_ready = 0); the producer must hold.

Decomposition:
- Shared package `uart_pkg`:
  - Constants UART_OVS = 16 and SYSCLK_HZ = 50_000_000.
  - Divisor constants for 9600/19200/115200 (integer and fractional parts).
  - A divisor typedef {int, frac}.
- One sub-module, `frac_period_cnt`:
  - Contains cnt, frac_acc, pending apply, and os_tick generation.
  - The top level keeps os_cnt, bit_tick, brclk, restart and the cfg handshake.

Test Plan:
- Defaults, en = 1:
  - os_tick periods alternate 325/326 cycles.
  - bit_tick spacing is 5208 cycles; brclk high/low is 2604 cycles each.
- Configure int = 10, frac = 8, then restart:
  - os_tick spacing alternates 10, 11.
  - First bit_tick at 84 cycles after restart; subsequent bit_ticks every 168 cycles.
- Configure int = 1:
  - cfg_err pulses for one cycle; cur_div is unchanged; cfg_ready stays 1.
- Configure int = 20 mid-period, with int = 10 active:
  - The current period still ends at 10 cycles (frac 0).
  - cfg_ready is low until the apply cycle.
  - Following os_ticks are spaced 20 cycles.
- en low for 37 cycles mid-period:
  - The tick-to-tick interval stretches by exactly 37.
  - bit_tick count over 3 bits is exact.
- Assert reset during pending config and mid-bit:
  - All outputs return to reset values the next cycle; cur_div = 325/8; brclk = 1.
